// File: rtl/risc_regfile_responder.sv
// Register-file responder: two latency-matched read ports (A, B) and one write-back port.
// Define REGFILE_WR_BYPASS_EN to forward a same-edge write into a read capture.
module risc_regfile_responder #(
  parameter int XLEN         = 32,
  parameter int ADDR_W       = 5,
  parameter int NUM_REGS     = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic              rd_addr_a_valid,
  output logic [XLEN-1:0]   rd_data_a,
  output logic              rd_data_a_ack,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic              rd_addr_b_valid,
  output logic [XLEN-1:0]   rd_data_b,
  output logic              rd_data_b_ack,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic              wr_valid,
  output logic              wr_ack
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } rd_state_t;

  localparam logic [2:0] CNT_INIT = 3'(READ_LATENCY - 1);

  if (NUM_REGS != (1 << ADDR_W) || READ_LATENCY < 1 || READ_LATENCY > 7) begin : g_bad_cfg
    $error("risc_regfile_responder: illegal parameter combination");
  end

  function automatic logic [XLEN-1:0] zero_x0(input logic [ADDR_W-1:0] addr,
                                              input logic [XLEN-1:0]   word);
    return (addr == '0) ? '0 : word;
  endfunction

  logic [XLEN-1:0] regs [NUM_REGS];
  logic            wr_fire;
  logic            wr_ack_q;

  // Write-back port: a held request fires once, then the ack cycle blocks re-acceptance.
  assign wr_fire = wr_valid && !wr_ack_q;
  assign wr_ack  = wr_ack_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ack_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      wr_ack_q <= wr_fire;
      if (wr_fire && wr_addr != '0) begin
        regs[wr_addr] <= wr_data;
      end
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic              req_vld;
    logic [ADDR_W-1:0] req_addr;
    rd_state_t         state;
    rd_state_t         state_nxt;
    logic [2:0]        cnt;
    logic [2:0]        cnt_nxt;
    logic [ADDR_W-1:0] addr_p0;
    logic [ADDR_W-1:0] addr_nxt;
    logic              capture;
    logic [XLEN-1:0]   cap_data;
    logic              vld_p1;
    logic [XLEN-1:0]   data_p1;

    assign req_vld  = (p == 0) ? rd_addr_a_valid : rd_addr_b_valid;
    assign req_addr = (p == 0) ? rd_addr_a       : rd_addr_b;

    // Stage p0: request acceptance and latency countdown
    always_ff @(posedge clk) begin
      if (reset) begin
        state   <= S_IDLE;
        cnt     <= 3'd0;
        addr_p0 <= '0;
      end else begin
        state   <= state_nxt;
        cnt     <= cnt_nxt;
        addr_p0 <= addr_nxt;
      end
    end

    // A request still held during its own ack cycle must not be taken a second time.
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      addr_nxt  = addr_p0;
      case (state)
        S_IDLE: begin
          if (req_vld && !vld_p1) begin
            addr_nxt  = req_addr;
            cnt_nxt   = CNT_INIT;
            state_nxt = (CNT_INIT == 3'd0) ? S_ACK : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_nxt = cnt - 3'd1;
          if (cnt == 3'd1) begin
            state_nxt = S_ACK;
          end
        end
        S_ACK:   state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end

    // The array is read before this edge's write lands, so a same-edge write is not seen.
    always_comb begin
      capture  = (state == S_ACK);
      cap_data = zero_x0(addr_p0, regs[addr_p0]);
`ifdef REGFILE_WR_BYPASS_EN
      if (wr_fire && wr_addr == addr_p0 && addr_p0 != '0) begin
        cap_data = wr_data;
      end
`endif
    end

    // Stage p1: registered ack pulse and held read data
    always_ff @(posedge clk) begin
      if (reset) begin
        vld_p1  <= 1'b0;
        data_p1 <= '0;
      end else begin
        vld_p1 <= capture;
        if (capture) begin
          data_p1 <= cap_data;
        end
      end
    end
  end

  assign rd_data_a     = g_port[0].data_p1;
  assign rd_data_a_ack = g_port[0].vld_p1;
  assign rd_data_b     = g_port[1].data_p1;
  assign rd_data_b_ack = g_port[1].vld_p1;

endmodule

// File: tb/tb_risc_regfile_responder.sv
// Bench for risc_regfile_responder: latency-1 and latency-3 instances share one stimulus
// stream and are compared every cycle against an edge-numbered reference model.
module tb_risc_regfile_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rd_addr_a, rd_addr_b, wr_addr;
  logic        rd_addr_a_valid, rd_addr_b_valid, wr_valid;
  logic [31:0] wr_data;
  logic [31:0] a1_data, b1_data, a3_data, b3_data;
  logic        a1_ack, b1_ack, a3_ack, b3_ack, w1_ack, w3_ack;

  int errors = 0;
  int checks = 0;

`ifdef REGFILE_WR_BYPASS_EN
  localparam logic [31:0] EXP_SAME_EDGE = 32'h0000_1234;
  localparam logic [31:0] EXP_COLL      = 32'h0000_0022;
`else
  localparam logic [31:0] EXP_SAME_EDGE = 32'h0000_0000;
  localparam logic [31:0] EXP_COLL      = 32'h0000_0011;
`endif

  always #5 clk = ~clk;

  risc_regfile_responder #(.XLEN(32), .ADDR_W(5), .NUM_REGS(32), .READ_LATENCY(1)) u_lat1 (
    .clk(clk), .reset(reset),
    .rd_addr_a(rd_addr_a), .rd_addr_a_valid(rd_addr_a_valid),
    .rd_data_a(a1_data), .rd_data_a_ack(a1_ack),
    .rd_addr_b(rd_addr_b), .rd_addr_b_valid(rd_addr_b_valid),
    .rd_data_b(b1_data), .rd_data_b_ack(b1_ack),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ack(w1_ack)
  );

  risc_regfile_responder #(.XLEN(32), .ADDR_W(5), .NUM_REGS(32), .READ_LATENCY(3)) u_lat3 (
    .clk(clk), .reset(reset),
    .rd_addr_a(rd_addr_a), .rd_addr_a_valid(rd_addr_a_valid),
    .rd_data_a(a3_data), .rd_data_a_ack(a3_ack),
    .rd_addr_b(rd_addr_b), .rd_addr_b_valid(rd_addr_b_valid),
    .rd_data_b(b3_data), .rd_data_b_ack(b3_ack),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ack(w3_ack)
  );

  // Reference model: each accepted read is due LAT edges later; a port reopens two edges after
  // its capture (the ack cycle ignores a still-held request).
  logic [31:0] mem [32];
  bit          m_pend    [2][2];
  logic [4:0]  m_addr    [2][2];
  int          m_due     [2][2];
  int          m_next_ok [2][2];
  logic        m_ack     [2][2];
  logic [31:0] m_data    [2][2];
  logic        m_wack = 1'b0;
  int          edge_n = 0;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic model_edge();
    logic        wfire;
    logic        v;
    logic [4:0]  a;
    logic [31:0] cap;
    wfire = wr_valid && !m_wack;
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'd0;
      for (int k = 0; k < 2; k++) begin
        for (int p = 0; p < 2; p++) begin
          m_pend[k][p] = 1'b0; m_addr[k][p] = 5'd0; m_due[k][p] = 0;
          m_next_ok[k][p] = 0; m_ack[k][p] = 1'b0; m_data[k][p] = 32'd0;
        end
      end
      m_wack = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        for (int p = 0; p < 2; p++) begin
          v = (p == 0) ? rd_addr_a_valid : rd_addr_b_valid;
          a = (p == 0) ? rd_addr_a : rd_addr_b;
          m_ack[k][p] = 1'b0;
          if (m_pend[k][p] && m_due[k][p] == edge_n) begin
            cap = (m_addr[k][p] == 5'd0) ? 32'd0 : mem[m_addr[k][p]];
`ifdef REGFILE_WR_BYPASS_EN
            if (wfire && wr_addr == m_addr[k][p] && m_addr[k][p] != 5'd0) cap = wr_data;
`endif
            m_data[k][p]    = cap;
            m_ack[k][p]     = 1'b1;
            m_pend[k][p]    = 1'b0;
            m_next_ok[k][p] = edge_n + 2;
          end else if (!m_pend[k][p] && edge_n >= m_next_ok[k][p] && v) begin
            m_pend[k][p] = 1'b1;
            m_addr[k][p] = a;
            m_due[k][p]  = edge_n + lat_of(k);
          end
        end
      end
      if (wfire && wr_addr != 5'd0) mem[wr_addr] = wr_data;
      m_wack = wfire;
    end
    edge_n++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("lat1_a_ack",  32'(a1_ack), 32'(m_ack[0][0]));
    chk("lat1_b_ack",  32'(b1_ack), 32'(m_ack[0][1]));
    chk("lat1_a_data", a1_data,     m_data[0][0]);
    chk("lat1_b_data", b1_data,     m_data[0][1]);
    chk("lat1_wr_ack", 32'(w1_ack), 32'(m_wack));
    chk("lat3_a_ack",  32'(a3_ack), 32'(m_ack[1][0]));
    chk("lat3_b_ack",  32'(b3_ack), 32'(m_ack[1][1]));
    chk("lat3_a_data", a3_data,     m_data[1][0]);
    chk("lat3_b_data", b3_data,     m_data[1][1]);
    chk("lat3_wr_ack", 32'(w3_ack), 32'(m_wack));
  endtask

  // Inputs are set at a falling edge; the next rising edge consumes them.
  task automatic step();
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1'b1;
    rd_addr_a = 5'd0; rd_addr_b = 5'd0; wr_addr = 5'd0;
    rd_addr_a_valid = 1'b0; rd_addr_b_valid = 1'b0; wr_valid = 1'b0; wr_data = 32'd0;
    idle(2);
    chk("reset_a1_ack", 32'(a1_ack), 32'd0);
    chk("reset_a3_data", a3_data, 32'd0);
    chk("reset_wr_ack", 32'(w1_ack), 32'd0);

    // Paired read of x5 / x7 right after reset
    reset = 1'b0;
    rd_addr_a = 5'd5; rd_addr_b = 5'd7; rd_addr_a_valid = 1'b1; rd_addr_b_valid = 1'b1;
    step();
    step();
    chk("pair_lat1_a_ack", 32'(a1_ack), 32'd1);
    chk("pair_lat1_b_ack", 32'(b1_ack), 32'd1);
    chk("pair_lat1_a_data", a1_data, 32'd0);
    step();
    chk("pair_lat1_a_ack_drop", 32'(a1_ack), 32'd0);
    chk("pair_lat1_b_ack_drop", 32'(b1_ack), 32'd0);
    step();
    chk("pair_lat3_a_ack", 32'(a3_ack), 32'd1);
    chk("pair_lat3_b_ack", 32'(b3_ack), 32'd1);
    rd_addr_a_valid = 1'b0; rd_addr_b_valid = 1'b0;
    idle(4);

    // Write x5 then read it back while valid is still held through the ack cycle
    wr_addr = 5'd5; wr_data = 32'h0000_00AA; wr_valid = 1'b1;
    step();
    chk("wr_x5_ack", 32'(w1_ack), 32'd1);
    wr_valid = 1'b0;
    step();
    chk("wr_x5_ack_drop", 32'(w1_ack), 32'd0);
    rd_addr_a = 5'd5; rd_addr_a_valid = 1'b1;
    step();
    step();
    chk("rd_x5_lat1_ack", 32'(a1_ack), 32'd1);
    chk("rd_x5_lat1_data", a1_data, 32'h0000_00AA);
    step();
    chk("rd_x5_lat1_single_ack", 32'(a1_ack), 32'd0);
    step();
    chk("rd_x5_lat3_data", a3_data, 32'h0000_00AA);
    rd_addr_a_valid = 1'b0;
    idle(4);

    // x0 writes are acked but discarded
    wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF; wr_valid = 1'b1;
    step();
    chk("wr_x0_ack", 32'(w1_ack), 32'd1);
    wr_valid = 1'b0;
    rd_addr_a = 5'd0; rd_addr_a_valid = 1'b1;
    step();
    step();
    chk("rd_x0_lat1_data", a1_data, 32'd0);
    step();
    step();
    chk("rd_x0_lat3_data", a3_data, 32'd0);
    rd_addr_a_valid = 1'b0;
    idle(4);

    // Write landing inside the latency-3 wait window is visible to the read
    rd_addr_a = 5'd9; rd_addr_a_valid = 1'b1;
    step();
    wr_addr = 5'd9; wr_data = 32'h0000_1234; wr_valid = 1'b1;
    step();
    chk("same_edge_lat1_data", a1_data, EXP_SAME_EDGE);
    wr_valid = 1'b0;
    step();
    step();
    chk("wait_window_lat3_ack", 32'(a3_ack), 32'd1);
    chk("wait_window_lat3_data", a3_data, 32'h0000_1234);
    rd_addr_a_valid = 1'b0;
    idle(4);

    // Collision: write lands on the capture edge of the latency-3 read
    wr_addr = 5'd3; wr_data = 32'h0000_0011; wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    step();
    rd_addr_a = 5'd3; rd_addr_a_valid = 1'b1;
    idle(3);
    wr_addr = 5'd3; wr_data = 32'h0000_0022; wr_valid = 1'b1;
    step();
    chk("collision_lat3_data", a3_data, EXP_COLL);
    wr_valid = 1'b0; rd_addr_a_valid = 1'b0;
    idle(4);

    // Reset while port B waits: the request vanishes and the array clears
    rd_addr_b = 5'd5; rd_addr_b_valid = 1'b1;
    step();
    step();
    reset = 1'b1; rd_addr_b_valid = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("reset_drop_lat3_b_ack", 32'(b3_ack), 32'd0);
    end
    for (int r = 0; r < 16; r++) begin
      rd_addr_a = 5'(r); rd_addr_b = 5'(r + 16);
      rd_addr_a_valid = 1'b1; rd_addr_b_valid = 1'b1;
      idle(4);
      chk("post_reset_lat3_a_data", a3_data, 32'd0);
      chk("post_reset_lat3_b_data", b3_data, 32'd0);
      rd_addr_a_valid = 1'b0; rd_addr_b_valid = 1'b0;
      step();
    end

    // Randomized traffic over a small address range to provoke collisions
    for (int i = 0; i < 500; i++) begin
      reset           = ($urandom_range(0, 59) == 0);
      rd_addr_a_valid = 1'($urandom_range(0, 1));
      rd_addr_b_valid = 1'($urandom_range(0, 1));
      rd_addr_a       = 5'($urandom_range(0, 7));
      rd_addr_b       = 5'($urandom_range(0, 7));
      wr_valid        = ($urandom_range(0, 2) != 0);
      wr_addr         = 5'($urandom_range(0, 7));
      wr_data         = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
